// File: rtl/irq_controller.sv
// 16-source interrupt controller: edge-detected flags, per-source enables, per-group priority.
// Optional IRQ_SYNC_EN adds a 2-flop synchronizer on irq_src ahead of edge detection.
module irq_controller #(
  parameter logic [23:0] BASE_ADDR = 24'h2020,
  parameter int          NUM_SRC   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cpu_write,
  input  logic               cpu_read,
  input  logic [23:0]        address_in,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  output logic               reg_hit,
  output logic [1:0]         irq_level,
  output logic [3:0]         irq_vector
);

  logic [NUM_SRC-1:0] irq_src_q;
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] event_s;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [NUM_SRC-1:0] flag_q, flag_d;
  logic [NUM_SRC-1:0] clr_s, set_s;
  logic [7:0]         prio_q, prio_d;
  logic [1:0]         irq_level_q, irq_level_d;
  logic [3:0]         irq_vector_q, irq_vector_d;
  logic [1:0]         grp_prio_s;
  logic [23:0]        offset_s;
  logic               in_range_s;
  logic               wr_s;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irq_src;
`endif

  // Wrap-around subtraction makes addresses below BASE_ADDR land far out of range.
  assign offset_s   = address_in - BASE_ADDR;
  assign in_range_s = (offset_s <= 24'd5);
  assign wr_s       = cpu_write & in_range_s;
  assign reg_hit    = cpu_read & in_range_s;
  assign event_s    = src_s & ~irq_src_q;

  always_comb begin
    prio_d = prio_q;
    en_d   = en_q;
    clr_s  = '0;
    set_s  = '0;
    if (wr_s) begin
      case (offset_s)
        24'd0:   prio_d      = data_in;
        24'd1:   en_d[7:0]   = data_in;
        24'd2:   en_d[15:8]  = data_in;
        24'd3:   clr_s[7:0]  = data_in;
        24'd4:   clr_s[15:8] = data_in;
        24'd5:   set_s[7:0]  = data_in;
        default: ;
      endcase
    end else begin
      clr_s = '0;
    end
    // Setting (edge or software) is applied after clearing so a collision keeps the flag.
    flag_d = (flag_q & ~clr_s) | event_s | set_s;
  end

  always_comb begin
    irq_level_d  = 2'd0;
    irq_vector_d = 4'd0;
    grp_prio_s   = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      grp_prio_s = prio_q[2*(i/4) +: 2];
      if (flag_q[i] && en_q[i] && (grp_prio_s != 2'd0) && (grp_prio_s >= irq_level_d)) begin
        irq_level_d  = grp_prio_s;
        irq_vector_d = 4'(i);
      end else begin
        irq_level_d  = irq_level_d;
      end
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (reg_hit) begin
      case (offset_s)
        24'd0:   data_out = prio_q;
        24'd1:   data_out = en_q[7:0];
        24'd2:   data_out = en_q[15:8];
        24'd3:   data_out = flag_q[7:0];
        24'd4:   data_out = flag_q[15:8];
        default: data_out = 8'h00;
      endcase
    end else begin
      data_out = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_src_q    <= '0;
      prio_q       <= 8'h00;
      en_q         <= '0;
      flag_q       <= '0;
      irq_level_q  <= 2'd0;
      irq_vector_q <= 4'd0;
    end else begin
      irq_src_q    <= src_s;
      prio_q       <= prio_d;
      en_q         <= en_d;
      flag_q       <= flag_d;
      irq_level_q  <= irq_level_d;
      irq_vector_q <= irq_vector_d;
    end
  end

  assign irq_level  = irq_level_q;
  assign irq_vector = irq_vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Randomized and directed bench for irq_controller against a behavioural register/arbitration model.
module tb_irq_controller;
  localparam logic [23:0] BASE = 24'h2020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] irq_src = 16'h0000;
  logic        cpu_write = 1'b0;
  logic        cpu_read = 1'b0;
  logic [23:0] address_in = 24'h000000;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        reg_hit;
  logic [1:0]  irq_level;
  logic [3:0]  irq_vector;

  irq_controller #(.BASE_ADDR(BASE), .NUM_SRC(16)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .cpu_write(cpu_write),
    .cpu_read(cpu_read), .address_in(address_in), .data_in(data_in),
    .data_out(data_out), .reg_hit(reg_hit), .irq_level(irq_level), .irq_vector(irq_vector)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // model state
  bit [15:0] m_flag, m_en, m_prev;
  bit [7:0]  m_prio;
  int        m_lvl, m_vec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int group_prio(input int src);
    return (int'(m_prio) >> (2 * (src / 4))) % 4;
  endfunction

  function automatic bit addr_hit(input logic [23:0] a);
    return (a >= BASE) && (a <= BASE + 24'd5);
  endfunction

  function automatic logic [7:0] m_read(input logic [23:0] a);
    if (!addr_hit(a)) return 8'h00;
    case (int'(a - BASE))
      0: return m_prio;
      1: return m_en[7:0];
      2: return m_en[15:8];
      3: return m_flag[7:0];
      4: return m_flag[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_clear();
    m_flag = '0; m_en = '0; m_prev = '0; m_prio = '0; m_lvl = 0; m_vec = 0;
  endtask

  // One rising edge worth of behaviour, using the inputs currently driven.
  task automatic model_step();
    int best_l, best_v, off;
    bit [15:0] clr, sw_set;
    best_l = 0; best_v = 0; clr = '0; sw_set = '0;
    for (int p = 3; p >= 1; p--)
      for (int i = 0; i < 16; i++)
        if (best_l == 0 && m_flag[i] && m_en[i] && group_prio(i) == p) begin
          best_l = p; best_v = i;
        end
    if (cpu_write && addr_hit(address_in)) begin
      off = int'(address_in - BASE);
      if (off == 0) m_prio = data_in;
      if (off == 1) m_en[7:0] = data_in;
      if (off == 2) m_en[15:8] = data_in;
      if (off == 3) clr[7:0] = data_in;
      if (off == 4) clr[15:8] = data_in;
      if (off == 5) sw_set[7:0] = data_in;
    end
    for (int i = 0; i < 16; i++) begin
      if ((irq_src[i] && !m_prev[i]) || sw_set[i]) m_flag[i] = 1'b1;
      else if (clr[i]) m_flag[i] = 1'b0;
    end
    m_prev = irq_src;
    m_lvl = best_l;
    m_vec = best_v;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("irq_level", {30'd0, irq_level}, m_lvl);
    check("irq_vector", {28'd0, irq_vector}, m_vec);
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    cpu_write = 1'b1; address_in = BASE + 24'(off); data_in = d;
    tick();
    cpu_write = 1'b0;
  endtask

  task automatic rdc(input int off, input logic [7:0] exp, input string tag);
    cpu_read = 1'b1; address_in = BASE + 24'(off);
    #1;
    check(tag, {24'd0, data_out}, {24'd0, exp});
    check({tag, "_hit"}, {31'd0, reg_hit}, 32'd1);
    cpu_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    do_reset();
    for (int k = 0; k < 6; k++) rdc(k, 8'h00, "reset_reg");
    cpu_read = 1'b1; address_in = BASE + 24'd6; #1;
    check("oob_hit", {31'd0, reg_hit}, 32'd0);
    check("oob_data", {24'd0, data_out}, 32'd0);
    cpu_read = 1'b0;
    tick();

    // basic request
    wr(0, 8'h03); wr(1, 8'h01);
    irq_src = 16'h0001; tick();
    irq_src = 16'h0000; tick();
    check("basic_lvl", {30'd0, irq_level}, 32'd3);
    check("basic_vec", {28'd0, irq_vector}, 32'd0);
    rdc(3, 8'h01, "basic_flag");

    // asynchronous reset in the middle of a cycle
    @(posedge clk); #3 reset = 1'b1; #1;
    check("async_rst_lvl", {30'd0, irq_level}, 32'd0);
    check("async_rst_vec", {28'd0, irq_vector}, 32'd0);
    @(negedge clk); reset = 1'b0; model_clear();
    for (int k = 0; k < 5; k++) rdc(k, 8'h00, "midrst_reg");
    tick();

    // priority and tie-break
    wr(0, 8'h42); wr(1, 8'hFF); wr(2, 8'hFF);
    irq_src = 16'h2006; tick();
    irq_src = 16'h0000; tick();
    check("prio_lvl", {30'd0, irq_level}, 32'd2);
    check("prio_vec", {28'd0, irq_vector}, 32'd1);
    wr(3, 8'h06); tick();
    check("prio2_lvl", {30'd0, irq_level}, 32'd1);
    check("prio2_vec", {28'd0, irq_vector}, 32'd13);
    wr(4, 8'h20); tick();

    // masking
    wr(2, 8'h00); wr(0, 8'h52);
    irq_src = 16'h0200; tick();
    irq_src = 16'h0000; tick();
    rdc(4, 8'h02, "mask_flag");
    check("mask_lvl", {30'd0, irq_level}, 32'd0);
    wr(2, 8'h02);
    check("unmask_lat_lvl", {30'd0, irq_level}, 32'd0);
    tick();
    check("unmask_lvl", {30'd0, irq_level}, 32'd1);
    check("unmask_vec", {28'd0, irq_vector}, 32'd9);
    wr(4, 8'h02); tick();

    // set/clear collision
    irq_src = 16'h0008; wr(3, 8'h08);
    rdc(3, 8'h08, "collide_flag");
    irq_src = 16'h0000; wr(3, 8'h08);
    rdc(3, 8'h00, "collide_clr");

    // held-high source through reset
    irq_src = 16'h0020; do_reset(); tick();
    rdc(3, 8'h20, "held_flag");
    wr(3, 8'h20); tick(); tick();
    rdc(3, 8'h00, "held_noreset");
    irq_src = 16'h0000;

    // software set, low byte only
    wr(5, 8'h81);
    rdc(3, 8'h81, "sw_set");
    rdc(5, 8'h00, "set_reads0");
    wr(3, 8'hFF);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      irq_src = irq_src ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      address_in = BASE - 24'd2 + 24'($urandom_range(0, 9));
      cpu_read = 1'($urandom);
      cpu_write = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      #1;
      check("rnd_hit", {31'd0, reg_hit}, {31'd0, cpu_read && addr_hit(address_in)});
      check("rnd_data", {24'd0, data_out}, cpu_read ? {24'd0, m_read(address_in)} : 32'd0);
      tick();
      cpu_write = 1'b0; cpu_read = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller feeding the s1c88 core's interrupt inputs inside the minx top level.
- Edge-detects 16 peripheral interrupt sources and latches them into flag registers.
- Applies per-source enables and per-group priorities, then presents the highest-priority pending request (level + source index) to the CPU.
- Exposes its registers in the 0x2000–0x20FF I/O page. The top-level read mux selects data_out when reg_hit is high.

Parameters:
- BASE_ADDR, 24'h2020, address of first register; register map occupies BASE_ADDR+0 .. BASE_ADDR+5.
- NUM_SRC, 16, number of interrupt sources; fixed at 16 (4 groups of 4), other values unsupported.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- irq_src  input  16  peripheral interrupt lines, active-high, rising edge = event
- cpu_write  input  1  CPU write strobe
- cpu_read  input  1  CPU read strobe
- address_in  input  24  CPU address
- data_in  input  8  CPU write data
- data_out  output  8  register read data
- reg_hit  output  1  high when cpu_read and address_in in register range
- irq_level  output  2  priority of selected request; 0 = no request
- irq_vector  output  4  index of selected source (0..15)

Behaviour:
- One clock (clk). Reset is asynchronous, active-high (reset); every flop is cleared on assertion regardless of clk.
- Register map, offsets from BASE_ADDR:
  - +0 PRIO: bits[2g+1:2g] = priority of group g (sources 4g..4g+3); 0 = group disabled. Read/write. Reset 8'h00.
  - +1 EN_LO: enable for sources 7..0. Read/write. Reset 8'h00.
  - +2 EN_HI: enable for sources 15..8. Read/write. Reset 8'h00.
  - +3 FLAG_LO: flags for sources 7..0. Read; write-1-to-clear. Reset 8'h00.
  - +4 FLAG_HI: flags for sources 15..8. Read; write-1-to-clear. Reset 8'h00.
  - +5 SET: write-only software trigger; a 1 in bit b sets flag b (low byte only). Reads 8'h00.
- Edge detect:
  - irq_src_q registers irq_src each cycle; reset value 0.
  - Event[i] = irq_src[i] & ~irq_src_q[i].
  - A source held high from reset produces one event, on the first cycle after reset deasserts.
- Flags:
  - flag[i] is set on event[i] regardless of enable. Enable gates only arbitration.
  - Flags are cleared only by a W1C write.
  - Set and W1C clear of the same bit in the same cycle: set wins (flag stays 1).
- Bus:
  - A write is applied on every cycle cpu_write is high with a matching address. Repeated writes are idempotent.
  - Writes to unmapped offsets inside the range are ignored.
  - data_out is combinational from address_in; reads have no side effects.
  - reg_hit = cpu_read & (address_in in BASE_ADDR..BASE_ADDR+5). data_out = 0 when reg_hit is low.
- Arbitration:
  - Candidate i = flag[i] & en[i] & (PRIO group ≠ 0).
  - Winner = candidate with highest group priority; ties broken by lowest source index.
  - irq_level/irq_vector are registered: they reflect flag/enable/priority state of the previous cycle (1-cycle latency).
  - No candidate: irq_level = 0, irq_vector = 0.
- Latency:
  - irq_src rising edge (cycle N) → flag set at edge N+1 → irq_level valid after edge N+2.
  - W1C clear at edge M → output updates after edge M+1.
- Reset mid-operation: flags, enables, priorities and outputs return to 0 immediately. No pending events are preserved.

Optional Feature:
- IRQ_SYNC_EN defined: irq_src passes through a 2-flop synchronizer before edge detect. Event-to-irq_level latency grows by 2 cycles (edge N → output after edge N+4). Synchronizer flops reset to 0.
- Not defined: irq_src is used directly (sources are assumed synchronous to clk).

Test Plan:
- Reset values: assert reset mid-cycle → irq_level=0, irq_vector=0 asynchronously; all registers read 8'h00.
- Basic request: PRIO=8'h03, EN_LO=8'h01, pulse irq_src[0] one cycle → FLAG_LO reads 8'h01; irq_level=3, irq_vector=0 exactly 2 edges after pulse.
- Priority/tie-break: PRIO=8'b01_00_00_10 (g3=1, g0=2), enable all, trigger sources 13, 2, 1 together → irq_vector=1, level=2. W1C FLAG_LO=8'h06 → vector=13, level=1.
- Masking: EN_HI=0, trigger source 9 → FLAG_HI=8'h02, irq_level=0. Write EN_HI=8'h02 with PRIO g2≠0 → request appears 1 cycle later.
- Set/clear collision: W1C FLAG_LO bit3 in the same cycle as a source-3 rising edge → FLAG_LO bit3 remains 1.
- Held-high source: irq_src[5] high through reset deassertion → single flag set; W1C clears it and it does not re-set while the line stays high.
